// File: rtl/entropy_conditioner.sv
// Raw ring-oscillator bits -> von Neumann debias -> LFSR whitening -> DATA_W-bit word packer,
// guarded by a repetition-count health test that latches a terminal fault.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_WARMUP | debiased bits stir the LFSR only; nothing is packed
// ST_RUN    | debiased bits are whitened and packed into output words
// ST_FAIL   | repetition-count failure; output withheld until rst
module entropy_conditioner #(
    parameter int          DATA_W    = 256,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468,
    parameter int          RCT_LIMIT = 32,
    parameter int          WARMUP    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              raw_bit,
    input  logic              raw_valid,
    output logic [DATA_W-1:0] entropy_o,
    output logic              entropy_valid,
    input  logic              entropy_ready,
    output logic              health_fail,
    output logic              ovf_o,
    output logic [1:0]        state_o
);

    localparam logic [1:0] ST_WARMUP = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FAIL   = 2'd2;

    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int RUN_W  = $clog2(RCT_LIMIT + 1);
    localparam int WARM_W = $clog2(WARMUP + 1);

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [RUN_W-1:0]  RUN_LIM   = RUN_W'(RCT_LIMIT);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);

    logic [1:0]        state;
    logic [31:0]       lfsr;
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  bit_cnt;
    logic [RUN_W-1:0]  run_cnt;
    logic [WARM_W-1:0] warm_cnt;
    logic              pair_full;
    logic              pair_bit;
    logic              prev_bit;

    logic              fb;
    logic              w_bit;
    logic              d_valid;
    logic              rct_trip;
    logic              consume;
    logic [RUN_W-1:0]  run_next;
    logic [DATA_W-1:0] acc_next;

    always_comb begin
        fb       = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];
        // pair 10 yields d=1 and 01 yields d=0, so d is simply the first sample
        w_bit    = fb ^ pair_bit;
        acc_next = {acc[DATA_W-2:0], w_bit};
        // run_cnt==0 means no previous sample since reset
        if (run_cnt != '0 && raw_bit == prev_bit)
            run_next = (run_cnt == RUN_LIM) ? run_cnt : run_cnt + 1'b1;
        else
            run_next = RUN_W'(1);
        rct_trip = raw_valid && (state != ST_FAIL) && (run_next == RUN_LIM);
        d_valid  = raw_valid && (state != ST_FAIL) && !rct_trip &&
                   pair_full && (pair_bit != raw_bit);
        consume  = entropy_valid && entropy_ready && (state != ST_FAIL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_WARMUP;
            lfsr          <= LFSR_SEED;
            acc           <= '0;
            bit_cnt       <= '0;
            run_cnt       <= '0;
            warm_cnt      <= '0;
            pair_full     <= 1'b0;
            pair_bit      <= 1'b0;
            prev_bit      <= 1'b0;
            entropy_o     <= '0;
            entropy_valid <= 1'b0;
            health_fail   <= 1'b0;
            ovf_o         <= 1'b0;
        end else if (state != ST_FAIL) begin
            // A held full accumulator moves straight into the freed output register.
            if (consume) begin
                if (bit_cnt == CNT_FULL) begin
                    entropy_o <= acc;
                    bit_cnt   <= '0;
                end else begin
                    entropy_valid <= 1'b0;
                end
            end

            if (raw_valid) begin
                run_cnt  <= run_next;
                prev_bit <= raw_bit;
                if (rct_trip) begin
                    state         <= ST_FAIL;
                    health_fail   <= 1'b1;
                    entropy_valid <= 1'b0;
                    entropy_o     <= '0;
                    acc           <= '0;
                    bit_cnt       <= '0;
                    pair_full     <= 1'b0;
                end else begin
                    pair_full <= !pair_full;
                    if (!pair_full)
                        pair_bit <= raw_bit;

                    if (d_valid) begin
                        lfsr <= {lfsr[30:0], w_bit};
                        if (state == ST_WARMUP) begin
                            warm_cnt <= warm_cnt + 1'b1;
                            if (warm_cnt == WARM_LAST)
                                state <= ST_RUN;
                        end else if (bit_cnt == CNT_FULL) begin
                            ovf_o <= 1'b1;
                        end else begin
                            acc <= acc_next;
                            if (bit_cnt == CNT_LAST) begin
                                if (!entropy_valid || consume) begin
                                    entropy_o     <= acc_next;
                                    entropy_valid <= 1'b1;
                                    bit_cnt       <= '0;
                                end else begin
                                    bit_cnt <= CNT_FULL;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_entropy_conditioner.sv
// Directed bench for entropy_conditioner (DATA_W=8, WARMUP=4, RCT_LIMIT=8) with a word scoreboard.
module tb_entropy_conditioner;

    localparam int          DW   = 8;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          raw_bit = 1'b0;
    logic          raw_valid = 1'b0;
    logic [DW-1:0] entropy_o;
    logic          entropy_valid;
    logic          entropy_ready = 1'b0;
    logic          health_fail;
    logic          ovf_o;
    logic [1:0]    state_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];

    entropy_conditioner #(
        .DATA_W(DW), .LFSR_SEED(SEED), .RCT_LIMIT(8), .WARMUP(4)
    ) dut (
        .clk(clk), .rst(rst), .raw_bit(raw_bit), .raw_valid(raw_valid),
        .entropy_o(entropy_o), .entropy_valid(entropy_valid),
        .entropy_ready(entropy_ready), .health_fail(health_fail),
        .ovf_o(ovf_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference whitened bit number idx (0-based) for a constant debiased stream d from seed.
    function automatic logic ref_w(input logic d, input int idx);
        logic [31:0] l;
        logic        f;
        logic        w;
        l = SEED;
        w = 1'b0;
        for (int i = 0; i <= idx; i++) begin
            f = l[31] ^ l[21] ^ l[1] ^ l[0];
            w = f ^ d;
            l = {l[30:0], w};
        end
        return w;
    endfunction

    function automatic logic [DW-1:0] ref_word(input logic d, input int start);
        logic [DW-1:0] v;
        v = '0;
        for (int k = 0; k < DW; k++)
            v = {v[DW-2:0], ref_w(d, start + k)};
        return v;
    endfunction

    task automatic send_bit(input logic b);
        raw_bit   = b;
        raw_valid = 1'b1;
        @(posedge clk);
        #1;
        raw_valid = 1'b0;
    endtask

    task automatic send_pairs(input logic a, input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(a);
            send_bit(b);
        end
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every accepted word is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!rst && entropy_valid && entropy_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h expected no word", entropy_o);
            end else begin
                check("word", 32'(entropy_o), 32'(exp_q.pop_front()));
            end
        end
    end

    logic [DW-1:0] word_s2, word1, word2;

    initial begin
        word_s2 = ref_word(1'b1, 4);
        word1   = ref_word(1'b0, 4);
        word2   = ref_word(1'b0, 12);

        #3;
        check("rst_entropy_o", 32'(entropy_o), 0);
        check("rst_valid", 32'(entropy_valid), 0);
        check("rst_state", 32'(state_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 12 pairs "10" with ready high
        entropy_ready = 1'b1;
        exp_q.push_back(word_s2);
        send_pairs(1'b1, 1'b0, 11);
        send_bit(1'b1);
        check("s2_valid_before_last", 32'(entropy_valid), 0);
        send_bit(1'b0);
        check("s2_valid_after_24th", 32'(entropy_valid), 1);
        check("s2_state_run", 32'(state_o), 1);
        @(posedge clk);
        #1;
        check("s2_valid_after_accept", 32'(entropy_valid), 0);
        check("s2_entropy_kept", 32'(entropy_o), 32'(word_s2));

        // 00/11 pairs produce no debiased bits and a run of only 2
        for (int i = 0; i < 25; i++) begin
            send_pairs(1'b0, 1'b0, 1);
            send_pairs(1'b1, 1'b1, 1);
        end
        check("s3_valid", 32'(entropy_valid), 0);
        check("s3_health", 32'(health_fail), 0);

        // asynchronous reset between edges
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("s1_entropy_o", 32'(entropy_o), 0);
        check("s1_valid", 32'(entropy_valid), 0);
        check("s1_health", 32'(health_fail), 0);
        check("s1_ovf", 32'(ovf_o), 0);
        check("s1_state", 32'(state_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // backpressure: word1 held, word2 in acc, word3 dropped
        entropy_ready = 1'b0;
        send_pairs(1'b0, 1'b1, 20);
        check("s4_valid", 32'(entropy_valid), 1);
        check("s4_word1_held", 32'(entropy_o), 32'(word1));
        check("s4_ovf_not_yet", 32'(ovf_o), 0);
        send_pairs(1'b0, 1'b1, 8);
        check("s4_ovf", 32'(ovf_o), 1);
        check("s4_word1_still", 32'(entropy_o), 32'(word1));
        exp_q.push_back(word1);
        exp_q.push_back(word2);
        entropy_ready = 1'b1;
        @(posedge clk);
        #1;
        entropy_ready = 1'b0;
        check("s4_valid_after_pulse", 32'(entropy_valid), 1);
        check("s4_word2", 32'(entropy_o), 32'(word2));
        entropy_ready = 1'b1;
        @(posedge clk);
        #1;
        entropy_ready = 1'b0;
        check("s4_valid_drained", 32'(entropy_valid), 0);

        // reset mid-word discards partial acc and reseeds
        rst_pulse();
        entropy_ready = 1'b1;
        send_pairs(1'b1, 1'b0, 9);
        check("s6_partial_valid", 32'(entropy_valid), 0);
        check("s6_partial_state", 32'(state_o), 1);
        rst_pulse();
        exp_q.push_back(word_s2);
        send_pairs(1'b1, 1'b0, 12);
        @(posedge clk);
        #1;
        check("s6_valid_after_accept", 32'(entropy_valid), 0);

        // health failure with a held word present
        rst_pulse();
        entropy_ready = 1'b0;
        send_pairs(1'b1, 1'b0, 12);
        check("s5_word_held", 32'(entropy_o), 32'(word_s2));
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        check("s5_health_at_7", 32'(health_fail), 0);
        check("s5_valid_at_7", 32'(entropy_valid), 1);
        send_bit(1'b1);
        check("s5_health", 32'(health_fail), 1);
        check("s5_state_fail", 32'(state_o), 2);
        check("s5_valid", 32'(entropy_valid), 0);
        check("s5_entropy_o", 32'(entropy_o), 0);
        entropy_ready = 1'b1;
        send_pairs(1'b0, 1'b1, 12);
        entropy_ready = 1'b0;
        check("s5_health_sticky", 32'(health_fail), 1);
        check("s5_state_sticky", 32'(state_o), 2);
        check("s5_valid_sticky", 32'(entropy_valid), 0);
        check("s5_entropy_sticky", 32'(entropy_o), 0);

        repeat (2) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
